// File: rtl/multicycle_alu_unit.sv
// Multicycle ALU: decodes ALUOp/Funct, runs single-cycle ops in one edge and
// unsigned multiply/divide as WIDTH-step shift-add / restoring-division loops.
module multicycle_alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Hi,
    output logic             Zero,
    output logic             Illegal,
    output logic             DivByZero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_DIV = 3'd6;
    localparam logic [2:0] OP_ILL = 3'd7;

    logic [1:0]       state_r;
    logic [CNT_W-1:0] count_r;
    // op_r holds the multiplicand or divisor; work_hi_r/work_lo_r are the
    // running {partial product, multiplier} or {remainder, dividend/quotient}.
    logic [WIDTH-1:0] op_r;
    logic [WIDTH-1:0] work_hi_r;
    logic [WIDTH-1:0] work_lo_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] hi_r;
    logic             zero_r;
    logic             illegal_r;
    logic             dbz_r;
    logic             out_valid_r;

    logic [2:0]       op_s;
    logic [WIDTH-1:0] single_res_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH-1:0] mul_hi_s;
    logic [WIDTH-1:0] mul_lo_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH:0]   div_trial_s;
    logic [WIDTH-1:0] div_hi_s;
    logic [WIDTH-1:0] div_lo_s;
    logic [WIDTH-1:0] fin_result_s;
    logic [WIDTH-1:0] fin_hi_s;
    logic             fin_illegal_s;
    logic             fin_dbz_s;
    logic             last_step_s;

    // Decode ALUOp/Funct into an internal operation code.
    always_comb begin
        op_s = OP_ILL;
        case (ALUOp)
            2'b00: op_s = OP_ADD;
            2'b01: op_s = OP_SUB;
            2'b10: begin
                case (Funct)
                    6'b100000: op_s = OP_ADD;
                    6'b100010: op_s = OP_SUB;
                    6'b100100: op_s = OP_AND;
                    6'b100101: op_s = OP_OR;
                    6'b101010: op_s = OP_SLT;
                    6'b011001: op_s = OP_MUL;
                    6'b011011: op_s = OP_DIV;
                    default:   op_s = OP_ILL;
                endcase
            end
            default: op_s = OP_ILL;
        endcase
    end

    // Single-cycle result computed straight from the request operands.
    always_comb begin
        single_res_s = {WIDTH{1'b0}};
        case (op_s)
            OP_ADD:  single_res_s = A + B;
            OP_SUB:  single_res_s = A - B;
            OP_AND:  single_res_s = A & B;
            OP_OR:   single_res_s = A | B;
            OP_SLT:  single_res_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default: single_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Shift-add step: conditionally add multiplicand, then shift {hi,lo} right.
    assign mul_sum_s = {1'b0, work_hi_r} + ({1'b0, op_r} & {(WIDTH+1){work_lo_r[0]}});
    assign mul_hi_s  = mul_sum_s[WIDTH:1];
    assign mul_lo_s  = {mul_sum_s[0], work_lo_r[WIDTH-1:1]};

    // Restoring-division step: shift in next dividend bit, subtract if it fits.
    assign div_shift_s = {work_hi_r, work_lo_r[WIDTH-1]};
    assign div_trial_s = div_shift_s - {1'b0, op_r};

    // Pick restored or reduced remainder depending on the trial borrow.
    always_comb begin
        div_hi_s = div_shift_s[WIDTH-1:0];
        div_lo_s = {work_lo_r[WIDTH-2:0], 1'b0};
        if (div_trial_s[WIDTH] == 1'b0) begin
            div_hi_s = div_trial_s[WIDTH-1:0];
            div_lo_s = {work_lo_r[WIDTH-2:0], 1'b1};
        end else begin
            div_hi_s = div_shift_s[WIDTH-1:0];
            div_lo_s = {work_lo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Final values loaded into the output registers on entry to DONE.
    always_comb begin
        fin_result_s  = single_res_s;
        fin_hi_s      = {WIDTH{1'b0}};
        fin_illegal_s = (op_s == OP_ILL);
        fin_dbz_s     = 1'b0;
        case (state_r)
            ST_MUL: begin
                fin_result_s  = mul_lo_s;
                fin_hi_s      = mul_hi_s;
                fin_illegal_s = 1'b0;
            end
            ST_DIV: begin
                fin_result_s  = div_lo_s;
                fin_hi_s      = div_hi_s;
                fin_illegal_s = 1'b0;
            end
            default: begin
                if (op_s == OP_DIV) begin
                    fin_result_s  = {WIDTH{1'b1}};
                    fin_hi_s      = A;
                    fin_illegal_s = 1'b0;
                    fin_dbz_s     = 1'b1;
                end else begin
                    fin_dbz_s     = 1'b0;
                end
            end
        endcase
    end

    assign last_step_s = (count_r == CNT_W'(WIDTH - 1));

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            count_r     <= {CNT_W{1'b0}};
            op_r        <= {WIDTH{1'b0}};
            work_hi_r   <= {WIDTH{1'b0}};
            work_lo_r   <= {WIDTH{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            hi_r        <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            illegal_r   <= 1'b0;
            dbz_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        count_r <= {CNT_W{1'b0}};
                        if (op_s == OP_MUL) begin
                            op_r      <= A;
                            work_hi_r <= {WIDTH{1'b0}};
                            work_lo_r <= B;
                            state_r   <= ST_MUL;
                        end else if ((op_s == OP_DIV) && (B != {WIDTH{1'b0}})) begin
                            op_r      <= B;
                            work_hi_r <= {WIDTH{1'b0}};
                            work_lo_r <= A;
                            state_r   <= ST_DIV;
                        end else begin
                            result_r    <= fin_result_s;
                            hi_r        <= fin_hi_s;
                            zero_r      <= (fin_result_s == {WIDTH{1'b0}});
                            illegal_r   <= fin_illegal_s;
                            dbz_r       <= fin_dbz_s;
                            out_valid_r <= 1'b1;
                            state_r     <= ST_DONE;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    work_hi_r <= (state_r == ST_MUL) ? mul_hi_s : div_hi_s;
                    work_lo_r <= (state_r == ST_MUL) ? mul_lo_s : div_lo_s;
                    count_r   <= count_r + CNT_W'(1);
                    if (last_step_s) begin
                        result_r    <= fin_result_s;
                        hi_r        <= fin_hi_s;
                        zero_r      <= (fin_result_s == {WIDTH{1'b0}});
                        illegal_r   <= fin_illegal_s;
                        dbz_r       <= fin_dbz_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = out_valid_r;
    assign Result    = result_r;
    assign Hi        = hi_r;
    assign Zero      = zero_r;
    assign Illegal   = illegal_r;
    assign DivByZero = dbz_r;

endmodule

// File: tb/tb_multicycle_alu_unit.sv
// Directed-vector bench for multicycle_alu_unit at WIDTH=32 with hand-computed
// expectations, latency counting and backpressure/reset-abort scenarios.
module tb_multicycle_alu_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ALUOp;
    logic [5:0]  Funct;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic [31:0] Hi;
    logic        Zero;
    logic        Illegal;
    logic        DivByZero;

    int passed;
    int total;
    int lat;
    bit rdy_seen;

    multicycle_alu_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .Funct(Funct), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .Hi(Hi), .Zero(Zero), .Illegal(Illegal),
        .DivByZero(DivByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request, let the accepting edge pass, scramble the inputs,
    // then count edges (accept edge = 1) until out_valid, bounded at 100.
    task automatic do_op(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         output int latency, output bit ready_seen);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        ALUOp = op; Funct = fn; A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; A = 32'hDEADBEEF; B = 32'h00000005;
        ALUOp = 2'b11; Funct = 6'h3F;
        latency = 1;
        ready_seen = 1'b0;
        while (!out_valid && latency < 100) begin
            ready_seen = ready_seen | in_ready;
            @(posedge clk); #1;
            latency++;
        end
    endtask

    // One edge with out_ready high to return to IDLE.
    task automatic release_out();
        @(posedge clk); #1;
    endtask

    initial begin
        passed = 0; total = 0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        ALUOp = 2'b00; Funct = 6'b000000; A = 32'd0; B = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", Result, 32'd0);
        check("rst_hi", Hi, 32'd0);
        check("rst_flags", {29'd0, Zero, Illegal, DivByZero}, 32'd0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // add 5+7
        do_op(2'b00, 6'b000000, 32'd5, 32'd7, lat, rdy_seen);
        check("add_latency", 32'(lat), 32'd1);
        check("add_result", Result, 32'd12);
        check("add_hi", Hi, 32'd0);
        check("add_zero", 32'(Zero), 32'd0);
        release_out();
        check("add_out_valid_drop", 32'(out_valid), 32'd0);

        // R-type sub 9-9
        do_op(2'b10, 6'b100010, 32'd9, 32'd9, lat, rdy_seen);
        check("sub_result", Result, 32'd0);
        check("sub_zero", 32'(Zero), 32'd1);
        release_out();

        // ALUOp=01 sub with wrap-around
        do_op(2'b01, 6'b000000, 32'd3, 32'd5, lat, rdy_seen);
        check("sub_wrap_result", Result, 32'hFFFFFFFE);
        release_out();

        // slt signed: -1 < 1, then swapped
        do_op(2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, lat, rdy_seen);
        check("slt_neg_lt_pos", Result, 32'd1);
        release_out();
        do_op(2'b10, 6'b101010, 32'd1, 32'hFFFFFFFF, lat, rdy_seen);
        check("slt_pos_lt_neg", Result, 32'd0);
        check("slt_swap_zero", 32'(Zero), 32'd1);
        release_out();

        // and / or
        do_op(2'b10, 6'b100100, 32'h0000F0F0, 32'h00000FF0, lat, rdy_seen);
        check("and_result", Result, 32'h000000F0);
        release_out();
        do_op(2'b10, 6'b100101, 32'h0000F0F0, 32'h00000FF0, lat, rdy_seen);
        check("or_result", Result, 32'h0000FFF0);
        release_out();

        // multu 0xFFFFFFFF * 2
        do_op(2'b10, 6'b011001, 32'hFFFFFFFF, 32'd2, lat, rdy_seen);
        check("mul_latency", 32'(lat), 32'd33);
        check("mul_in_ready_low", 32'(rdy_seen), 32'd0);
        check("mul_hi", Hi, 32'd1);
        check("mul_lo", Result, 32'hFFFFFFFE);
        check("mul_zero", 32'(Zero), 32'd0);
        release_out();

        // multu 0x12345678 * 0x9ABCDEF0 = 0x0B00EA4E_242D2080
        do_op(2'b10, 6'b011001, 32'h12345678, 32'h9ABCDEF0, lat, rdy_seen);
        check("mul2_hi", Hi, 32'h0B00EA4E);
        check("mul2_lo", Result, 32'h242D2080);
        release_out();

        // divu 100/7
        do_op(2'b10, 6'b011011, 32'd100, 32'd7, lat, rdy_seen);
        check("div_latency", 32'(lat), 32'd33);
        check("div_in_ready_low", 32'(rdy_seen), 32'd0);
        check("div_quot", Result, 32'd14);
        check("div_rem", Hi, 32'd2);
        check("div_dbz", 32'(DivByZero), 32'd0);
        release_out();

        // divu 0xFFFFFFFF / 0x10 -> 0x0FFFFFFF rem 0xF
        do_op(2'b10, 6'b011011, 32'hFFFFFFFF, 32'h00000010, lat, rdy_seen);
        check("div2_quot", Result, 32'h0FFFFFFF);
        check("div2_rem", Hi, 32'h0000000F);
        release_out();

        // Backpressure on a single-cycle add
        out_ready = 1'b0;
        do_op(2'b00, 6'b000000, 32'h00001234, 32'h00000001, lat, rdy_seen);
        check("bp_latency", 32'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid_hold", 32'(out_valid), 32'd1);
            check("bp_result_hold", Result, 32'h00001235);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_idle_hold", Result, 32'h00001235);

        // Illegal R-type funct and illegal ALUOp
        do_op(2'b10, 6'b000111, 32'd11, 32'd22, lat, rdy_seen);
        check("ill_latency", 32'(lat), 32'd1);
        check("ill_flag", 32'(Illegal), 32'd1);
        check("ill_result", Result, 32'd0);
        check("ill_hi", Hi, 32'd0);
        release_out();
        do_op(2'b11, 6'b100000, 32'd11, 32'd22, lat, rdy_seen);
        check("ill_aluop_flag", 32'(Illegal), 32'd1);
        release_out();

        // divu by zero
        do_op(2'b10, 6'b011011, 32'd100, 32'd0, lat, rdy_seen);
        check("dbz_latency", 32'(lat), 32'd1);
        check("dbz_result", Result, 32'hFFFFFFFF);
        check("dbz_hi", Hi, 32'd100);
        check("dbz_flag", 32'(DivByZero), 32'd1);
        check("dbz_illegal", 32'(Illegal), 32'd0);
        release_out();

        // Reset in the middle of a multu
        check("abort_in_ready", 32'(in_ready), 32'd1);
        ALUOp = 2'b10; Funct = 6'b011001; A = 32'hFFFFFFFF; B = 32'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort_busy", 32'(in_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("abort_result", Result, 32'd0);
        check("abort_hi", Hi, 32'd0);
        check("abort_dbz", 32'(DivByZero), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        do_op(2'b00, 6'b000000, 32'd3, 32'd4, lat, rdy_seen);
        check("post_reset_latency", 32'(lat), 32'd1);
        check("post_reset_add", Result, 32'd7);
        check("post_reset_hi", Hi, 32'd0);
        release_out();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
